sprite_move_sched: RTL and testbench
====================================

Name: sprite_move_sched

Overview:
- Frame-rate move scheduler for the playfield sprites: the spaceship, bullets and asteroids.
- Once per video frame, at the start of vertical blanking, it walks the sprite slots in order. It issues each slot's single-pixpulse move strobe according to a per-slot speed divider.
- It also latches synchronized joystick buttons into a frame-stable direction vector for the spaceship.
- Sits between the VGA timing counters and all sprite blocks; it is the sole source of their move inputs.

Parameters:
- NUM_OBJ, 4, number of sprite slots; slot 0 is the spaceship.
- DIVW, 4, width of each per-slot speed divider.
- VSTART, 480, vcount value of the first blanking line (scan trigger line).

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous active-high reset
- pixpulse  input  1  one-clk enable every 4 clks (25 MHz pixel rate)
- hcount  input  10  current pixel x
- vcount  input  10  current pixel y
- pause  input  1  freeze all sprite motion
- obj_en  input  NUM_OBJ  per-slot enable
- obj_div  input  NUM_OBJ*DIVW  per-slot divider, slot i at [i*DIVW +: DIVW]; slot moves every obj_div+1 frames
- btn_raw  input  4  asynchronous buttons {U,D,L,R}
- move  output  NUM_OBJ  per-slot move strobe; at most one bit set
- ship_dir  output  4  latched {mU,mD,mL,mR} for the spaceship
- frame_tick  output  1  frame-start marker
- busy  output  1  scan in progress
- frame_cnt  output  16  count of unpaused frames

Behaviour:
Reset and update rules:
- Reset is synchronous, taking effect on the clk edge with rst high, regardless of pixpulse.
- Reset values: move=0, ship_dir=0, frame_tick=0, busy=0, frame_cnt=0, all divider counters=0, state=IDLE, slot index=0, synchronizer flops=0.
- btn_raw passes through a 2-flop synchronizer clocked every clk (not gated by pixpulse).
- All other state and outputs update only on clk edges where pixpulse=1. They hold between pixpulses, so each strobe spans exactly one following pixpulse.

FSM states: IDLE, SCAN.

IDLE:
- Frame event is pixpulse & vcount==VSTART & hcount==0.
- On a frame event: frame_tick<=1 and ship_dir<=synchronized buttons (also latched while paused).
- If pause=0: frame_cnt<=frame_cnt+1 (wraps FFFF->0000), busy<=1, index<=0, go to SCAN.
- If pause=1: stay in IDLE; counters and frame_cnt hold; no move is issued.
- On every other pixpulse: frame_tick<=0, move<=0.

SCAN (one slot per pixpulse, index i):
- frame_tick<=0.
- Slot enabled and counter==0: move<=one-hot(i), counter<=obj_div[i].
- Slot enabled and counter!=0: move<=0, counter<=counter-1.
- Slot disabled: move<=0, counter<=0, so a newly enabled slot moves on its first frame.
- obj_div is sampled only at reload; changes mid-scan affect only later reloads.
- When i==NUM_OBJ-1: next state IDLE, busy<=0. The last strobe is cleared on the next pixpulse by the IDLE default.
- pause asserted mid-scan does not abort the scan; it is sampled only at the frame event.

Timing:
- move[i] rises on the pixpulse edge i+1 after the frame event. The scan completes within NUM_OBJ+1 pixpulses, far inside the 45-line blanking interval.
- Latency from btn_raw change to ship_dir: 2 clks of synchronizer, then the next frame event.
- Opposing buttons are passed through unchanged; the sprite resolves them.
- rst mid-scan: immediate return to IDLE with all outputs at reset values; the next frame event starts a normal scan.

Test Plan:
- Defaults after reset: obj_en=4'b1111, obj_div all 0 -> frame event at vcount=480/hcount=0 gives frame_tick=1 for one pixpulse; move=0001,0010,0100,1000 on consecutive pixpulses, then 0000; busy high for 4 pixpulses; frame_cnt=1.
- Divider: obj_div slot2=2, others 0, run 6 frames -> slot2 moves in frames 1 and 4 only; slots 0,1,3 move every frame.
- Disable/enable: obj_en[1]=0 for 3 frames -> move[1] never asserted. Set obj_div[1]=3, re-enable -> move[1] in the first frame after enable, then every 4th frame.
- Pause: pause=1 across 2 frame events -> frame_tick pulses, move stays 0, frame_cnt and counters hold, ship_dir still updates. Release -> scan resumes with divider phase unchanged.
- Buttons: btn_raw=4'b1010 set mid-frame -> ship_dir stays old until next frame event, then 1010. Pulse btn_raw between frame events -> ship_dir does not change.
- Reset and wrap: assert rst during SCAN at index 2 -> move=0, busy=0 next clk, next frame scans from slot 0. Preload frame_cnt to FFFF via 65535 frames (or force) -> next frame gives 0000.

Source files
------------

// File: rtl/sprite_move_sched.sv
// rtl/sprite_move_sched.sv - per-frame sprite move strobe scheduler with ship direction latch
module sprite_move_sched #(
  parameter int NUM_OBJ = 4,
  parameter int DIVW    = 4,
  parameter int VSTART  = 480
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pixpulse,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic                      pause,
  input  logic [NUM_OBJ-1:0]        obj_en,
  input  logic [NUM_OBJ*DIVW-1:0]   obj_div,
  input  logic [3:0]                btn_raw,
  output logic [NUM_OBJ-1:0]        move,
  output logic [3:0]                ship_dir,
  output logic                      frame_tick,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NUM_OBJ*DIVW-1:0]   cnt_q, cnt_d;
  logic [NUM_OBJ-1:0]        move_q, move_d;
  logic [3:0]                dir_q, dir_d;
  logic                      tick_q, tick_d;
  logic                      busy_q, busy_d;
  logic [15:0]               fcnt_q, fcnt_d;
  logic [3:0]                btn_meta, btn_sync;

  logic                      frame_evt;
  logic [DIVW-1:0]           cur_cnt;
  logic [DIVW-1:0]           cur_div;

  // The frame trigger is the first pixel of the first blanking line; pixpulse gating is in the register.
  assign frame_evt = (vcount == 10'(VSTART)) && (hcount == 10'd0);
  assign cur_cnt   = cnt_q[idx_q*DIVW +: DIVW];
  assign cur_div   = obj_div[idx_q*DIVW +: DIVW];

  // Two-flop synchronizer for the asynchronous buttons, running on every clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Next-state and output logic: IDLE waits for the frame trigger, SCAN visits one slot per pixpulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    move_d  = '0;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    busy_d  = busy_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (frame_evt) begin
          tick_d = 1'b1;
          dir_d  = btn_sync;
          if (!pause) begin
            fcnt_d  = fcnt_q + 16'd1;
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (obj_en[idx_q]) begin
          if (cur_cnt == '0) begin
            move_d = NUM_OBJ'(1) << idx_q;
            cnt_d[idx_q*DIVW +: DIVW] = cur_div;
          end else begin
            cnt_d[idx_q*DIVW +: DIVW] = cur_cnt - DIVW'(1);
          end
        end else begin
          // A disabled slot is parked at zero so it moves on its first enabled frame.
          cnt_d[idx_q*DIVW +: DIVW] = '0;
        end
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state advances only on pixel-rate enables so each strobe lasts exactly one pixpulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      move_q  <= '0;
      dir_q   <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else if (pixpulse) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign move       = move_q;
  assign ship_dir   = dir_q;
  assign frame_tick = tick_q;
  assign busy       = busy_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_sprite_move_sched.sv
// tb/tb_sprite_move_sched.sv - scoreboard bench for sprite_move_sched
module tb_sprite_move_sched;

  localparam int NUM_OBJ = 4;
  localparam int DIVW    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pixpulse = 1'b0;
  logic [9:0]              hcount;
  logic [9:0]              vcount;
  logic                    pause;
  logic [NUM_OBJ-1:0]      obj_en;
  logic [NUM_OBJ*DIVW-1:0] obj_div;
  logic [3:0]              btn_raw;
  logic [NUM_OBJ-1:0]      move;
  logic [3:0]              ship_dir;
  logic                    frame_tick;
  logic                    busy;
  logic [15:0]             frame_cnt;

  sprite_move_sched #(.NUM_OBJ(NUM_OBJ), .DIVW(DIVW), .VSTART(480)) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .pause(pause), .obj_en(obj_en), .obj_div(obj_div), .btn_raw(btn_raw),
    .move(move), .ship_dir(ship_dir), .frame_tick(frame_tick), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic       tick;
    logic       busy;
    logic [3:0] move;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         mcnt[NUM_OBJ];
  logic [3:0] m_dir;
  logic [15:0] m_fc;

  always #5 clk = ~clk;

  // pixpulse every fourth clk, changed on the falling edge
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      pixpulse = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // advance to the clk edge that carries a pixpulse, then settle
  task automatic step();
    int guard = 0;
    @(posedge clk);
    while (!pixpulse && guard < 8) begin
      @(posedge clk);
      guard++;
    end
    if (!pixpulse) chk("pixpulse_timeout", 16'd0, 16'd1);
    #1;
  endtask

  task automatic idle(input int n);
    vcount = 10'd100;
    hcount = 10'd5;
    for (int k = 0; k < n; k++) step();
  endtask

  // model one frame: event entry, one entry per slot, then the clearing entry
  task automatic push_frame();
    exp_t e;
    e.tick = 1'b1; e.busy = !pause; e.move = '0;
    sb.push_back(e);
    m_dir = btn_raw;
    if (pause) begin
      for (int i = 0; i <= NUM_OBJ; i++) sb.push_back(exp_t'(6'b0));
    end else begin
      m_fc = m_fc + 16'd1;
      for (int i = 0; i < NUM_OBJ; i++) begin
        e.tick = 1'b0;
        e.busy = (i < NUM_OBJ - 1);
        e.move = '0;
        if (!obj_en[i]) mcnt[i] = 0;
        else if (mcnt[i] == 0) begin
          e.move = 4'(1 << i);
          mcnt[i] = int'(obj_div[i*DIVW +: DIVW]);
        end else mcnt[i] = mcnt[i] - 1;
        sb.push_back(e);
      end
      sb.push_back(exp_t'(6'b0));
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_move"}, 16'(move), 16'(e.move));
      chk({tag, "_tick"}, 16'(frame_tick), 16'(e.tick));
      chk({tag, "_busy"}, 16'(busy), 16'(e.busy));
    end
  endtask

  task automatic frame(input string tag);
    push_frame();
    vcount = 10'd480;
    hcount = 10'd0;
    step();
    vcount = 10'd481;
    hcount = 10'd1;
    pop_cmp({tag, "_evt"});
    chk({tag, "_dir"}, 16'(ship_dir), 16'(m_dir));
    for (int k = 0; k <= NUM_OBJ; k++) begin
      step();
      pop_cmp(tag);
    end
    chk({tag, "_fcnt"}, frame_cnt, m_fc);
  endtask

  initial begin
    rst = 1'b1; hcount = '0; vcount = 10'd100; pause = 1'b0;
    obj_en = 4'b1111; obj_div = '0; btn_raw = 4'b0000;
    for (int i = 0; i < NUM_OBJ; i++) mcnt[i] = 0;
    m_dir = '0; m_fc = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_move", 16'(move), 16'd0);
    chk("rst_dir", 16'(ship_dir), 16'd0);
    chk("rst_tick", 16'(frame_tick), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_fcnt", frame_cnt, 16'd0);
    rst = 1'b0;
    idle(2);

    frame("basic");

    obj_div[2*DIVW +: DIVW] = 4'd2;
    for (int f = 0; f < 6; f++) begin
      idle(2);
      frame("div2");
    end

    obj_en[1] = 1'b0;
    for (int f = 0; f < 3; f++) begin
      idle(2);
      frame("dis1");
    end
    obj_div[1*DIVW +: DIVW] = 4'd3;
    obj_en[1] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      idle(2);
      frame("reen1");
    end

    btn_raw = 4'b0101;
    pause = 1'b1;
    for (int f = 0; f < 2; f++) begin
      idle(2);
      frame("pause");
    end
    pause = 1'b0;
    for (int f = 0; f < 3; f++) begin
      idle(2);
      frame("resume");
    end

    btn_raw = 4'b1010;
    idle(3);
    chk("btn_hold", 16'(ship_dir), 16'(m_dir));
    frame("btn_new");
    btn_raw = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    btn_raw = 4'b1010;
    idle(2);
    chk("btn_pulse_hold", 16'(ship_dir), 16'(m_dir));
    frame("btn_pulse");

    idle(2);
    push_frame();
    vcount = 10'd480;
    hcount = 10'd0;
    step();
    vcount = 10'd481;
    hcount = 10'd1;
    pop_cmp("mid_evt");
    step();
    pop_cmp("mid_s0");
    step();
    pop_cmp("mid_s1");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_move", 16'(move), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_fcnt", frame_cnt, 16'd0);
    chk("midrst_dir", 16'(ship_dir), 16'd0);
    sb.delete();
    for (int i = 0; i < NUM_OBJ; i++) mcnt[i] = 0;
    m_dir = '0;
    m_fc = '0;
    idle(2);
    frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
